alarm_clock_keypad_scanner: RTL and testbench

- Front end of the alarm clock that produces the stimulus side of the clock's input interface: key[3:0], alarm_button, time_button, fast_watch.
- Scans a 4x3 matrix keypad with active-low rows and columns, synchronises and debounces the result, then encodes it.
  - Digits 0-9 become key codes; '*' becomes alarm_button; '#' becomes time_button.
- Outputs feed the alarm clock core directly, with the same encoding the core expects (key = 4'd10 means no key).

---
 rtl/alarm_clock_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 tb/tb_alarm_clock_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_keypad_scanner.sv
// Keypad front end for the alarm clock core.
// Scans a 4x3 active-low matrix keypad, synchronises and debounces the result
// and presents it to the core as key code, key_valid pulse, alarm/time
// buttons and a synchronised fast-watch level.
module alarm_clock_keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row_n,
    input  logic [2:0] col_n,
    input  logic       fast_watch_sw,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       alarm_button,
    output logic       time_button,
    output logic       fast_watch
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT - 1);

    // Internal key codes: 0-9 are digits, the rest are special
    localparam logic [3:0] CODE_NONE = 4'd10;
    localparam logic [3:0] CODE_STAR = 4'd11;
    localparam logic [3:0] CODE_HASH = 4'd12;
    localparam logic [3:0] CODE_MAXD = 4'd9;

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    // Map a (row, column) keypad position to its internal code
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case (row)
            2'd0:    code = 4'd1 + {2'b00, col};
            2'd1:    code = 4'd4 + {2'b00, col};
            2'd2:    code = 4'd7 + {2'b00, col};
            2'd3: begin
                case (col)
                    2'd0:    code = CODE_STAR;
                    2'd1:    code = 4'd0;
                    2'd2:    code = CODE_HASH;
                    default: code = CODE_NONE;
                endcase
            end
            default: code = CODE_NONE;
        endcase
        return code;
    endfunction

    logic          rst_meta_q, rst_sync_q;
    logic          rst_s;
    logic [2:0]    col_meta_q, col_sync_q;
    logic          fw_meta_q, fw_sync_q;

    state_t        state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [1:0]    hit_cnt_q, hit_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic [3:0]    frame_code_q, frame_code_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    accepted_q, accepted_d;
    logic          acc_new_q, acc_new_d;
    logic [3:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          alarm_q, alarm_d;
    logic          time_q, time_d;

    logic          sample_s;
    logic [1:0]    row_hits_s;
    logic [3:0]    row_code_s;
    logic [3:0]    merged_code_s;
    logic [2:0]    hit_total_s;
    logic [1:0]    hit_sat_s;

    // Reset synchroniser: assert immediately, release on a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_s = rst_sync_q;

    // Two-flop synchronisers for the asynchronous column and switch inputs
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            col_meta_q <= 3'b111;
            col_sync_q <= 3'b111;
            fw_meta_q  <= 1'b0;
            fw_sync_q  <= 1'b0;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            fw_meta_q  <= fast_watch_sw;
            fw_sync_q  <= fw_meta_q;
        end
    end

    assign sample_s = (dwell_q == DWELL_LAST);

    // Decode the columns seen on the current row and merge into the frame tally
    always_comb begin
        row_hits_s = 2'd0;
        row_code_s = CODE_NONE;
        for (int c = 0; c < 3; c++) begin
            if (!col_sync_q[c]) begin
                row_hits_s = row_hits_s + 2'd1;
                row_code_s = key_code(row_idx_q, 2'(c));
            end else begin
                row_hits_s = row_hits_s;
            end
        end
        hit_total_s   = {1'b0, hit_cnt_q} + {1'b0, row_hits_s};
        hit_sat_s     = (hit_total_s >= 3'd2) ? 2'd2 : hit_total_s[1:0];
        merged_code_s = (row_hits_s != 2'd0) ? row_code_s : acc_code_q;
    end

    // Row scan, frame accumulation and SCAN/EVAL debounce next-state logic
    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        dwell_d      = dwell_q;
        hit_cnt_d    = hit_cnt_q;
        acc_code_d   = acc_code_q;
        frame_code_d = frame_code_q;
        prev_code_d  = prev_code_q;
        stable_d     = stable_q;
        accepted_d   = accepted_q;
        acc_new_d    = 1'b0;

        // Row advance never pauses, including during EVAL
        if (sample_s) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
            if (row_idx_q == 2'd3) begin
                // Only a single key over the whole frame yields a code
                frame_code_d = (hit_total_s == 3'd1) ? merged_code_s : CODE_NONE;
                hit_cnt_d    = 2'd0;
                acc_code_d   = CODE_NONE;
            end else begin
                hit_cnt_d  = hit_sat_s;
                acc_code_d = merged_code_s;
            end
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
        row_n_d = ~(4'b0001 << row_idx_d);

        case (state_q)
            ST_SCAN: begin
                if (sample_s && (row_idx_q == 2'd3)) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_EVAL: begin
                state_d     = ST_SCAN;
                prev_code_d = frame_code_q;
                if (frame_code_q == prev_code_q) begin
                    stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
                end else begin
                    stable_d = '0;
                end
                if ((stable_d == STABLE_MAX) && (frame_code_q != accepted_q)) begin
                    accepted_d = frame_code_q;
                    acc_new_d  = 1'b1;
                end else begin
                    accepted_d = accepted_q;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Encode the accepted code into the core-facing outputs
    always_comb begin
        key_d       = CODE_NONE;
        key_valid_d = 1'b0;
        if (accepted_q <= CODE_MAXD) begin
            key_d       = accepted_q;
            key_valid_d = acc_new_q;
        end else begin
            key_d       = CODE_NONE;
            key_valid_d = 1'b0;
        end
        alarm_d = (accepted_q == CODE_STAR);
        time_d  = (accepted_q == CODE_HASH);
    end

    // State, scan and output registers
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q      <= ST_SCAN;
            row_idx_q    <= 2'd0;
            dwell_q      <= '0;
            row_n_q      <= 4'b1110;
            hit_cnt_q    <= 2'd0;
            acc_code_q   <= CODE_NONE;
            frame_code_q <= CODE_NONE;
            prev_code_q  <= CODE_NONE;
            stable_q     <= '0;
            accepted_q   <= CODE_NONE;
            acc_new_q    <= 1'b0;
            key_q        <= CODE_NONE;
            key_valid_q  <= 1'b0;
            alarm_q      <= 1'b0;
            time_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            dwell_q      <= dwell_d;
            row_n_q      <= row_n_d;
            hit_cnt_q    <= hit_cnt_d;
            acc_code_q   <= acc_code_d;
            frame_code_q <= frame_code_d;
            prev_code_q  <= prev_code_d;
            stable_q     <= stable_d;
            accepted_q   <= accepted_d;
            acc_new_q    <= acc_new_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            alarm_q      <= alarm_d;
            time_q       <= time_d;
        end
    end

    assign row_n        = row_n_q;
    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign alarm_button = alarm_q;
    assign time_button  = time_q;
    assign fast_watch   = fw_sync_q;

endmodule

// File: tb/tb_alarm_clock_keypad_scanner.sv
// Scoreboard bench for the keypad scanner: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_alarm_clock_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_n;
    logic [2:0]  col_n;
    logic        fast_watch_sw = 1'b0;
    logic [3:0]  key;
    logic        key_valid;
    logic        alarm_button;
    logic        time_button;
    logic        fast_watch;
    logic [11:0] pressed = 12'd0;  // index = row*3 + col

    localparam logic [1:0] EV_KV  = 2'd0;  // key_valid pulse with digit
    localparam logic [1:0] EV_K10 = 2'd1;  // key returned to 10
    localparam logic [1:0] EV_ALM = 2'd2;  // alarm_button changed
    localparam logic [1:0] EV_TIM = 2'd3;  // time_button changed

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   passed = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev_key = 4'd10;
    logic prev_alm = 1'b0;
    logic prev_tim = 1'b0;

    alarm_clock_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .row_n        (row_n),
        .col_n        (col_n),
        .fast_watch_sw(fast_watch_sw),
        .key          (key),
        .key_valid    (key_valid),
        .alarm_button (alarm_button),
        .time_button  (time_button),
        .fast_watch   (fast_watch)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column low while its row is driven
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_n[r] && pressed[r*3+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    endtask

    task automatic observe(input logic [1:0] kind, input logic [3:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: kind %0d value %0d, none expected", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("event", {26'd0, kind, val}, {26'd0, e.kind, e.val});
        end
    endtask

    // Monitor: turn output changes into events and compare against the queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_valid) observe(EV_KV, key);
            if (key == 4'd10 && prev_key != 4'd10) observe(EV_K10, 4'd10);
            if (alarm_button != prev_alm) observe(EV_ALM, {3'd0, alarm_button});
            if (time_button != prev_tim) observe(EV_TIM, {3'd0, time_button});
            prev_key <= key;
            prev_alm <= alarm_button;
            prev_tim <= time_button;
        end
    end

    task automatic push(input logic [1:0] kind, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Wait until every expected event has been seen, within a cycle budget
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL %s: %0d events pending after %0d cycles, expected 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] one;
        logic [3:0] exp_row;
        int n;
        one = 4'b0001;

        // Reset values
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_row_n", {28'd0, row_n}, 32'd14);
        check("rst_key", {28'd0, key}, 32'd10);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_alarm", {31'd0, alarm_button}, 32'd0);
        check("rst_time", {31'd0, time_button}, 32'd0);
        check("rst_fast_watch", {31'd0, fast_watch}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Row scan sequence: each row low for 4 cycles
        n = 0;
        while (row_n == 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 16; i++) begin
            exp_row = ~(one << ((i / 4 + 1) % 4));
            check("row_n_seq", {28'd0, row_n}, {28'd0, exp_row});
            @(negedge clk);
        end

        // Hold '5' for 200 cycles, then release
        idle(5);
        push(EV_KV, 4'd5);
        pressed[4] = 1'b1;
        drain("press_5", 68);
        idle(140);
        push(EV_K10, 4'd10);
        pressed[4] = 1'b0;
        drain("release_5", 68);
        idle(20);

        // Bouncing '8' must be rejected, steady '8' accepted once
        for (int i = 0; i < 12; i++) begin
            pressed[7] = (i % 2 == 0);
            repeat (5) @(negedge clk);
        end
        #1;
        check("bounce_key", {28'd0, key}, 32'd10);
        push(EV_KV, 4'd8);
        pressed[7] = 1'b1;
        drain("steady_8", 68);
        idle(20);
        push(EV_K10, 4'd10);
        pressed[7] = 1'b0;
        drain("release_8", 68);
        idle(20);

        // '*' drives alarm_button only
        push(EV_ALM, 4'd1);
        pressed[9] = 1'b1;
        drain("press_star", 68);
        check("star_key", {28'd0, key}, 32'd10);
        idle(20);
        push(EV_ALM, 4'd0);
        pressed[9] = 1'b0;
        drain("release_star", 68);
        idle(20);

        // '#' drives time_button only
        push(EV_TIM, 4'd1);
        pressed[11] = 1'b1;
        drain("press_hash", 68);
        check("hash_key", {28'd0, key}, 32'd10);
        idle(20);
        push(EV_TIM, 4'd0);
        pressed[11] = 1'b0;
        drain("release_hash", 68);
        idle(20);

        // Two keys together give no code; dropping '9' leaves '1'
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        idle(100);
        check("ghost_key", {28'd0, key}, 32'd10);
        push(EV_KV, 4'd1);
        pressed[8] = 1'b0;
        drain("single_1", 68);
        idle(20);
        push(EV_K10, 4'd10);
        pressed[0] = 1'b0;
        drain("release_1", 68);
        idle(20);

        // Reset while '3' is held: outputs clear at once, key re-accepted later
        push(EV_KV, 4'd3);
        pressed[2] = 1'b1;
        drain("press_3", 68);
        idle(20);
        push(EV_K10, 4'd10);
        #3 reset = 1'b1;
        #1;
        check("midrst_key", {28'd0, key}, 32'd10);
        check("midrst_row_n", {28'd0, row_n}, 32'd14);
        check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(EV_KV, 4'd3);
        drain("reaccept_3", 68);

        // fast_watch follows the switch two clocks later
        @(negedge clk);
        fast_watch_sw = 1'b1;
        @(negedge clk);
        check("fw_rise_1clk", {31'd0, fast_watch}, 32'd0);
        @(negedge clk);
        check("fw_rise_2clk", {31'd0, fast_watch}, 32'd1);
        fast_watch_sw = 1'b0;
        @(negedge clk);
        check("fw_fall_1clk", {31'd0, fast_watch}, 32'd1);
        @(negedge clk);
        check("fw_fall_2clk", {31'd0, fast_watch}, 32'd0);

        #1;
        push(EV_K10, 4'd10);
        pressed[2] = 1'b0;
        drain("release_3", 68);
        idle(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
